// File: rtl/puck_physics.sv
// Air-hockey puck engine: advances, reflects and scores the puck once per frame tick.
// Define FRICTION_EN to decay velocity by one on every 16th processed tick.
module puck_physics #(
    parameter int X_MIN      = 235,
    parameter int X_MAX      = 693,
    parameter int Y_MIN      = 112,
    parameter int Y_MAX      = 430,
    parameter int GOAL_YLO   = 246,
    parameter int GOAL_YHI   = 296,
    parameter int CX         = 464,
    parameter int CY         = 271,
    parameter int HIT_R2     = 625,
    parameter int VMAX       = 7,
    parameter int HOLD_TICKS = 30,
    parameter int WIN_SCORE  = 7
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic [9:0] mal1_x,
    input  logic [9:0] mal1_y,
    input  logic [9:0] mal2_x,
    input  logic [9:0] mal2_y,
    output logic [9:0] puck_x,
    output logic [9:0] puck_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       goal,
    output logic       game_over
);
    typedef enum logic [2:0] {
        S_WAIT, S_ADV, S_WALL, S_HIT, S_COMMIT, S_HOLD, S_OVER
    } state_t;

    localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
    localparam logic signed [10:0] GYLO_S = 11'(GOAL_YLO);
    localparam logic signed [10:0] GYHI_S = 11'(GOAL_YHI);
    localparam logic signed [10:0] VMAX_S = 11'(VMAX);

    state_t             state_q, state_d;
    logic [9:0]         px_q, px_d, py_q, py_d;
    logic signed [4:0]  vx_q, vx_d, vy_q, vy_d, vx_e, vy_e;
    logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
    logic [9:0]         m1x_q, m1x_d, m1y_q, m1y_d;
    logic [9:0]         m2x_q, m2x_d, m2y_q, m2y_d;
    logic [3:0]         s1_q, s1_d, s2_q, s2_d, s1_inc, s2_inc;
    logic               goal_q, goal_d;
    logic [4:0]         hcnt_q, hcnt_d;

    logic signed [10:0] nx_w, ny_w, dx1, dy1, dx2, dy2;
    logic signed [4:0]  vx_w, vy_w, vx_h, vy_h;
    logic               in_mouth, g1_w, g2_w, win_w, hold_done, c1, c2;

    function automatic logic [21:0] dist2(input logic signed [10:0] dx,
                                          input logic signed [10:0] dy);
        logic signed [21:0] ex, ey;
        ex = 22'(dx);
        ey = 22'(dy);
        return ex * ex + ey * ey;
    endfunction

    function automatic logic signed [4:0] sat(input logic signed [10:0] d);
        logic signed [10:0] s;
        s = d >>> 2;
        if (s > VMAX_S) return 5'(VMAX_S);
        else if (s < -VMAX_S) return 5'(-VMAX_S);
        return $signed(s[4:0]);
    endfunction

`ifdef FRICTION_EN
    logic [4:0] fcnt_q, fcnt_d;
    logic       fdec_q, fdec_d;

    function automatic logic signed [4:0] decay(input logic signed [4:0] v);
        if (v > 5'sd0) return v - 5'sd1;
        else if (v < 5'sd0) return v + 5'sd1;
        return v;
    endfunction

    // The decay flag is latched on the tick and consumed in ADV.
    always_comb begin
        fcnt_d = fcnt_q;
        fdec_d = fdec_q;
        if (state_q == S_WAIT && tick) begin
            fdec_d = (fcnt_q == 5'd15);
            fcnt_d = fdec_d ? 5'd0 : fcnt_q + 5'd1;
        end else if (state_q == S_WALL && (g1_w || g2_w)) begin
            fcnt_d = 5'd0;
            fdec_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fcnt_q <= 5'd0;
            fdec_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            fdec_q <= fdec_d;
        end
    end

    assign vx_e = fdec_q ? decay(vx_q) : vx_q;
    assign vy_e = fdec_q ? decay(vy_q) : vy_q;
`else
    assign vx_e = vx_q;
    assign vy_e = vy_q;
`endif

    // Y is clamped first so the goal-mouth test sees the clamped row.
    always_comb begin
        nx_w = nx_q;
        ny_w = ny_q;
        vx_w = vx_q;
        vy_w = vy_q;
        g1_w = 1'b0;
        g2_w = 1'b0;
        if (ny_q < YMIN_S) begin
            ny_w = YMIN_S;
            vy_w = -vy_q;
        end else if (ny_q > YMAX_S) begin
            ny_w = YMAX_S;
            vy_w = -vy_q;
        end
        in_mouth = (ny_w >= GYLO_S) && (ny_w <= GYHI_S);
        if (nx_q < XMIN_S) begin
            if (in_mouth) g2_w = 1'b1;
            else begin
                nx_w = XMIN_S;
                vx_w = -vx_q;
            end
        end else if (nx_q > XMAX_S) begin
            if (in_mouth) g1_w = 1'b1;
            else begin
                nx_w = XMAX_S;
                vx_w = -vx_q;
            end
        end
    end

    assign s1_inc    = (s1_q < 4'(WIN_SCORE)) ? s1_q + 4'd1 : s1_q;
    assign s2_inc    = (s2_q < 4'(WIN_SCORE)) ? s2_q + 4'd1 : s2_q;
    assign win_w     = g1_w ? (s1_inc == 4'(WIN_SCORE)) : (s2_inc == 4'(WIN_SCORE));
    assign hold_done = (hcnt_q == 5'(HOLD_TICKS - 1));

    assign dx1 = nx_q - $signed({1'b0, m1x_q});
    assign dy1 = ny_q - $signed({1'b0, m1y_q});
    assign dx2 = nx_q - $signed({1'b0, m2x_q});
    assign dy2 = ny_q - $signed({1'b0, m2y_q});
    assign c1  = dist2(dx1, dy1) < 22'(HIT_R2);
    assign c2  = dist2(dx2, dy2) < 22'(HIT_R2);

    // Mallet 1 has priority; a dead-centre hit still pushes the puck away.
    always_comb begin
        vx_h = vx_q;
        vy_h = vy_q;
        if (c1) begin
            vx_h = sat(dx1);
            vy_h = sat(dy1);
            if (vx_h == 5'sd0 && vy_h == 5'sd0) vx_h = 5'sd1;
        end else if (c2) begin
            vx_h = sat(dx2);
            vy_h = sat(dy2);
            if (vx_h == 5'sd0 && vy_h == 5'sd0) vx_h = -5'sd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT:   if (tick) state_d = S_ADV;
            S_ADV:    state_d = S_WALL;
            S_WALL: begin
                if (g1_w || g2_w) state_d = win_w ? S_OVER : S_HOLD;
                else              state_d = S_HIT;
            end
            S_HIT:    state_d = S_COMMIT;
            S_COMMIT: state_d = S_WAIT;
            S_HOLD:   if (tick && hold_done) state_d = S_WAIT;
            S_OVER:   state_d = S_OVER;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        px_d   = px_q;
        py_d   = py_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        nx_d   = nx_q;
        ny_d   = ny_q;
        m1x_d  = m1x_q;
        m1y_d  = m1y_q;
        m2x_d  = m2x_q;
        m2y_d  = m2y_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        goal_d = 1'b0;
        hcnt_d = hcnt_q;
        unique case (state_q)
            S_ADV: begin
                vx_d  = vx_e;
                vy_d  = vy_e;
                nx_d  = $signed({1'b0, px_q}) + 11'(vx_e);
                ny_d  = $signed({1'b0, py_q}) + 11'(vy_e);
                m1x_d = mal1_x;
                m1y_d = mal1_y;
                m2x_d = mal2_x;
                m2y_d = mal2_y;
            end
            S_WALL: begin
                if (g1_w || g2_w) begin
                    s1_d   = g1_w ? s1_inc : s1_q;
                    s2_d   = g2_w ? s2_inc : s2_q;
                    goal_d = 1'b1;
                    px_d   = 10'(CX);
                    py_d   = 10'(CY);
                    vx_d   = 5'sd0;
                    vy_d   = 5'sd0;
                    hcnt_d = 5'd0;
                end else begin
                    nx_d = nx_w;
                    ny_d = ny_w;
                    vx_d = vx_w;
                    vy_d = vy_w;
                end
            end
            S_HIT: begin
                vx_d = vx_h;
                vy_d = vy_h;
            end
            S_COMMIT: begin
                px_d = nx_q[9:0];
                py_d = ny_q[9:0];
            end
            S_HOLD: if (tick) hcnt_d = hold_done ? 5'd0 : hcnt_q + 5'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            px_q   <= 10'(CX);
            py_q   <= 10'(CY);
            vx_q   <= 5'sd0;
            vy_q   <= 5'sd0;
            nx_q   <= 11'sd0;
            ny_q   <= 11'sd0;
            m1x_q  <= 10'd0;
            m1y_q  <= 10'd0;
            m2x_q  <= 10'd0;
            m2y_q  <= 10'd0;
            s1_q   <= 4'd0;
            s2_q   <= 4'd0;
            goal_q <= 1'b0;
            hcnt_q <= 5'd0;
        end else begin
            px_q   <= px_d;
            py_q   <= py_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            nx_q   <= nx_d;
            ny_q   <= ny_d;
            m1x_q  <= m1x_d;
            m1y_q  <= m1y_d;
            m2x_q  <= m2x_d;
            m2y_q  <= m2y_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            goal_q <= goal_d;
            hcnt_q <= hcnt_d;
        end
    end

    always_comb begin
        puck_x    = px_q;
        puck_y    = py_q;
        score1    = s1_q;
        score2    = s2_q;
        goal      = goal_q;
        game_over = (state_q == S_OVER);
    end
endmodule

// File: tb/tb_puck_physics.sv
// Directed bench for puck_physics: hits, walls, goals, hold, game over, clr.
// Expected coordinates are hand-computed from the serve point and velocities.
module tb_puck_physics;
  logic       clk = 1'b0;
  logic       clr, tick;
  logic [9:0] m1x, m1y, m2x, m2y;
  logic [9:0] puck_x, puck_y;
  logic [3:0] score1, score2;
  logic       goal, game_over;
  int         n_chk = 0;
  int         n_fail = 0;
  int         g;
  bit         done = 1'b0;

  always #5 clk = ~clk;

  puck_physics dut (
    .clk(clk), .clr(clr), .tick(tick),
    .mal1_x(m1x), .mal1_y(m1y), .mal2_x(m2x), .mal2_y(m2y),
    .puck_x(puck_x), .puck_y(puck_y),
    .score1(score1), .score2(score2),
    .goal(goal), .game_over(game_over)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int ax, input int ay, input int bx, input int by);
    m1x = 10'(ax);
    m1y = 10'(ay);
    m2x = 10'(bx);
    m2y = 10'(by);
  endtask

  task automatic far();
    set_m(0, 0, 1000, 900);
  endtask

  task automatic do_tick();
    g = 0;
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (goal) g++;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #2 clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20_000_000;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: bench did not finish");
      $finish;
    end
  end

  initial begin
    clr  = 1'b1;
    tick = 1'b0;
    far();
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    n_chk++;
    if (puck_x !== 10'd464 || puck_y !== 10'd271 || score1 !== 4'd0 ||
        score2 !== 4'd0 || goal !== 1'b0 || game_over !== 1'b0) begin
      n_fail++;
      $error("FAIL reset state: x=%0d y=%0d s1=%0d s2=%0d g=%0b o=%0b",
             puck_x, puck_y, score1, score2, goal, game_over);
    end
    chk("rst_x", puck_x, 464);
    chk("rst_y", puck_y, 271);
    chk("rst_s1", score1, 0);
    chk("rst_s2", score2, 0);
    chk("rst_goal", goal, 0);
    chk("rst_over", game_over, 0);

    set_m(444, 271, 1000, 900);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    #2 clr = 1'b1;
    #2 clr = 1'b0;
    @(posedge clk);
    #1;
    chk("midclr_x", puck_x, 464);
    chk("midclr_y", puck_y, 271);
    far();
    ticks(2);
    chk("midclr_idle", puck_x, 464);

    set_m(444, 271, 1000, 900);
    do_tick();
    chk("hit_x", puck_x, 464);
    chk("hit_y", puck_y, 271);
    far();
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lat3", puck_x, 464);
    @(posedge clk);
    #1;
    chk("lat4", puck_x, 469);
    repeat (2) @(posedge clk);
    #1;
    do_tick();
    chk("roll", puck_x, 474);
    chk("roll_y", puck_y, 271);
    pulse_clr();

    set_m(0, 0, 464, 271);
    do_tick();
    far();
    do_tick();
    chk("m2_centre", puck_x, 463);
    pulse_clr();

    set_m(464, 271, 1000, 900);
    do_tick();
    far();
    do_tick();
    chk("m1_centre", puck_x, 465);
    pulse_clr();

    set_m(444, 271, 464, 271);
    do_tick();
    far();
    do_tick();
    chk("both_x", puck_x, 469);
    pulse_clr();

    set_m(481, 288, 1000, 900);
    do_tick();
    far();
    ticks(31);
    chk("diag_x", puck_x, 309);
    chk("diag_y", puck_y, 116);
    do_tick();
    chk("top_x", puck_x, 304);
    chk("top_y", puck_y, 112);
    ticks(13);
    chk("dl_x", puck_x, 239);
    chk("dl_y", puck_y, 177);
    do_tick();
    chk("left_x", puck_x, 235);
    chk("left_y", puck_y, 182);
    do_tick();
    chk("bounce_x", puck_x, 240);
    chk("bounce_y", puck_y, 187);
    pulse_clr();

    set_m(484, 271, 1000, 900);
    do_tick();
    far();
    ticks(45);
    chk("pre_lgoal", puck_x, 239);
    do_tick();
    chk("lgoal_pulse", g, 1);
    chk("lgoal_s2", score2, 1);
    chk("lgoal_s1", score1, 0);
    chk("lgoal_x", puck_x, 464);
    chk("lgoal_y", puck_y, 271);
    set_m(444, 271, 1000, 900);
    ticks(30);
    chk("hold_x", puck_x, 464);
    do_tick();
    chk("after_hold_hit", puck_x, 464);
    far();
    do_tick();
    chk("resume_x", puck_x, 469);
    pulse_clr();

    for (int r = 1; r <= 7; r++) begin
      set_m(444, 271, 1000, 900);
      do_tick();
      chk("rnd_hit", puck_x, 464);
      far();
      ticks(45);
      chk("rnd_pre", puck_x, 689);
      do_tick();
      chk("rnd_pulse", g, 1);
      chk("rnd_s1", score1, r);
      if (r < 7) begin
        chk("rnd_not_over", game_over, 0);
        set_m(444, 271, 1000, 900);
        ticks(30);
      end
    end
    chk("over", game_over, 1);
    chk("over_x", puck_x, 464);
    set_m(444, 271, 1000, 900);
    ticks(3);
    far();
    do_tick();
    chk("frozen_x", puck_x, 464);
    chk("frozen_y", puck_y, 271);
    chk("frozen_s1", score1, 7);
    chk("frozen_over", game_over, 1);
    pulse_clr();
    chk("clr_over", game_over, 0);
    chk("clr_s1", score1, 0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/puck_physics.md
Name: puck_physics

Overview:
Air-hockey puck engine that generates the puck position consumed by the VGA renderer.
- Inputs: both mallet positions and a 30 Hz frame tick.
- Each tick it advances the puck and reflects it off the board walls.
- Resolves mallet hits, detects goals, keeps score and flags game over.
- All coordinates are in raw hc/vc counter space.

Parameters:
X_MIN, 235, leftmost legal puck centre (inner wall 225 + radius 10)
X_MAX, 693, rightmost legal puck centre
Y_MIN, 112, topmost legal puck centre
Y_MAX, 430, bottommost legal puck centre
GOAL_YLO, 246, goal mouth low y (inclusive)
GOAL_YHI, 296, goal mouth high y (inclusive)
CX, 464, serve centre x
CY, 271, serve centre y
HIT_R2, 625, squared contact distance ((10+15)^2)
VMAX, 7, velocity magnitude limit per axis
HOLD_TICKS, 30, ticks puck rests at centre after a goal
WIN_SCORE, 7, score that ends the game

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-high
tick  in  1  one-clk pulse per frame (30 Hz)
mal1_x  in  10  mallet 1 centre x
mal1_y  in  10  mallet 1 centre y
mal2_x  in  10  mallet 2 centre x
mal2_y  in  10  mallet 2 centre y
puck_x  out  10  puck centre x, registered
puck_y  out  10  puck centre y, registered
score1  out  4  player 1 goals (scored in right goal)
score2  out  4  player 2 goals (scored in left goal)
goal  out  1  one-clk pulse on any goal
game_over  out  1  high once either score reaches WIN_SCORE

Behaviour:
- Reset values (async on clr):
  - puck_x=CX, puck_y=CY.
  - Internal vx=vy=0, signed 5-bit.
  - score1=score2=0, goal=0, game_over=0.
  - State WAIT.
- States: WAIT, ADV, WALL, HIT, COMMIT, HOLD, OVER.
- WAIT: on tick go to ADV; otherwise idle.
- ADV (1 clk):
  - nx=puck_x+vx, ny=puck_y+vy in signed 11-bit.
  - Mallet coordinates are sampled here into registers.
- WALL (1 clk):
  - ny<Y_MIN -> ny=Y_MIN, vy=-vy.
  - ny>Y_MAX -> ny=Y_MAX, vy=-vy.
  - nx<X_MIN with ny in [GOAL_YLO,GOAL_YHI]: goal for player 2 -> GOAL path.
  - nx<X_MIN otherwise: nx=X_MIN, vx=-vx.
  - nx>X_MAX: mirror of the left side; goal for player 1.
  - Y clamp is applied before the goal-window test.
- HIT (1 clk):
  - dx=nx-mal_x, dy=ny-mal_y, signed 11-bit; d2=dx*dx+dy*dy, 22-bit unsigned.
  - Contact when d2<HIT_R2.
  - Mallet 1 is checked first; if both mallets contact, mallet 1 wins.
  - On contact: vx=sat(dx>>>2), vy=sat(dy>>>2), saturating to ±VMAX.
  - If both results are 0: vx=+1 for mallet 1, -1 for mallet 2.
  - Position is not altered by a hit.
- COMMIT (1 clk): puck_x<=nx, puck_y<=ny, -> WAIT.
  - Outputs change only here, so total latency is tick -> puck update in 4 clks.
- GOAL path, taken instead of HIT/COMMIT:
  - Increment the scorer's count, saturating at WIN_SCORE.
  - goal=1 for exactly 1 clk.
  - puck=(CX,CY), vx=vy=0.
  - If the new score equals WIN_SCORE -> OVER, else -> HOLD.
- HOLD:
  - Count HOLD_TICKS ticks; mallets are ignored during the count.
  - Then -> WAIT with zero velocity. The puck only moves once a mallet touches it.
- OVER:
  - game_over=1, puck frozen at centre, ticks ignored.
  - Exited only by clr.
- A tick arriving in any state other than WAIT/HOLD is dropped, not queued.
- clr mid-computation abandons it; the next sequence starts fresh from WAIT.
- Velocity components are never outside ±VMAX; wall reflection of -VMAX... +VMAX stays in range.

Optional Feature:
FRICTION_EN:
- When defined: a 5-bit tick counter runs in WAIT. Every 16th processed tick, each nonzero velocity component moves 1 toward zero, applied in ADV before the add. The counter resets on clr and on goal.
- When undefined: velocity changes only by wall reflection or mallet hit.

Test Plan:
- clr pulse mid-ADV -> puck (464,271), scores 0, goal 0, state WAIT; next tick with no contact leaves puck at (464,271).
- Mallet 1 at (444,271), puck at centre, tick -> dx=20, vx=+5, vy=0; puck_x=464 after tick 1, 469 after tick 2, observed exactly 4 clks after each tick.
- Puck (690,120), v=(+5,-5), tick -> puck (693,115), v=(-5,-5); next tick -> puck (688,112), v=(-5,+5).
- Puck (238,270), vx=-5, tick -> score2=1, goal high 1 clk, puck (464,271); 30 further ticks with no motion, then resumes on contact.
- score1=6, right goal -> score1=7, game_over=1; subsequent ticks and mallet contact leave puck at (464,271) until clr.
- Both mallets overlap puck in the same tick -> velocity from mallet 1 only; with FRICTION_EN, vx=+5 decays to 4 after 16 ticks.
